// File: rtl/apb_gpio_seq.sv
// APB-programmable GPIO pattern sequencer: plays an 8-step (value, hold) table once or looped
// and raises a level interrupt when a one-shot sequence completes.
module apb_gpio_seq #(
  parameter int unsigned APB_ADDR_WIDTH = 12
) (
  input  logic                      HCLK,
  input  logic                      HRESET,
  input  logic [APB_ADDR_WIDTH-1:0] PADDR,
  input  logic [31:0]               PWDATA,
  input  logic                      PWRITE,
  input  logic                      PSEL,
  input  logic                      PENABLE,
  output logic [31:0]               PRDATA,
  output logic                      PREADY,
  output logic                      PSLVERR,
  output logic [31:0]               seq_out,
  output logic [31:0]               seq_mask,
  output logic                      seq_busy,
  output logic                      irq
);

  localparam logic [3:0] RegCtrl   = 4'h0;
  localparam logic [3:0] RegStatus = 4'h1;
  localparam logic [3:0] RegMask   = 4'h2;
  localparam logic [3:0] RegIdx    = 4'h3;
  localparam logic [3:0] RegValue  = 4'h4;
  localparam logic [3:0] RegHold   = 4'h5;

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e      state_q, state_d;
  logic [2:0]  step_q, step_d;
  logic [15:0] cnt_q, cnt_d;
  logic [31:0] out_q, out_d;
  logic        done_q, done_d;

  logic [31:0] mask_q;
  logic [2:0]  idx_q;
  logic        loop_q;
  logic [2:0]  last_q;

  logic [31:0] value_q [8];
  logic [15:0] hold_q [8];

  logic [3:0]  reg_sel;
  logic        apb_wr, apb_rd;
  logic        ctrl_start, ctrl_stop, status_rd;
  logic [2:0]  step_nxt;
  logic        unused_paddr;

  assign reg_sel      = PADDR[5:2];
  assign unused_paddr = ^{PADDR[APB_ADDR_WIDTH-1:6], PADDR[1:0]};
  assign apb_wr       = PSEL & PENABLE & PWRITE;
  assign apb_rd       = PSEL & PENABLE & ~PWRITE;
  assign ctrl_start   = apb_wr && (reg_sel == RegCtrl) && PWDATA[0];
  assign ctrl_stop    = apb_wr && (reg_sel == RegCtrl) && PWDATA[1];
  assign status_rd    = apb_rd && (reg_sel == RegStatus);
  assign step_nxt     = step_q + 3'd1;

  assign PREADY   = 1'b1;
  assign PSLVERR  = 1'b0;
  assign seq_out  = out_q;
  assign seq_mask = mask_q;
  assign seq_busy = (state_q == StRun);
  assign irq      = done_q;

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      mask_q <= 32'd0;
      idx_q  <= 3'd0;
      loop_q <= 1'b0;
      last_q <= 3'd0;
    end else if (apb_wr) begin
      unique case (reg_sel)
        RegCtrl: begin
          loop_q <= PWDATA[2];
          last_q <= PWDATA[6:4];
        end
        RegMask: mask_q <= PWDATA;
        RegIdx:  idx_q  <= PWDATA[2:0];
        default: ;
      endcase
    end
  end

  // Table storage is deliberately left unreset.
  always_ff @(posedge HCLK) begin
    if (apb_wr && (reg_sel == RegValue)) value_q[idx_q] <= PWDATA;
    if (apb_wr && (reg_sel == RegHold))  hold_q[idx_q]  <= PWDATA[15:0];
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q <= StIdle;
      step_q  <= 3'd0;
      cnt_q   <= 16'd0;
      out_q   <= 32'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    done_d  = done_q;
    // Read-clear first so a completion on the same edge overrides it.
    if (status_rd) done_d = 1'b0;
    if (ctrl_stop) begin
      state_d = StIdle;
    end else if (ctrl_start) begin
      state_d = StRun;
      step_d  = 3'd0;
      out_d   = value_q[0];
      cnt_d   = hold_q[0];
      done_d  = 1'b0;
    end else if (state_q == StRun) begin
      if (cnt_q != 16'd0) begin
        cnt_d = cnt_q - 16'd1;
      end else if (step_q != last_q) begin
        step_d = step_nxt;
        out_d  = value_q[step_nxt];
        cnt_d  = hold_q[step_nxt];
      end else if (loop_q) begin
        step_d = 3'd0;
        out_d  = value_q[0];
        cnt_d  = hold_q[0];
      end else begin
        state_d = StIdle;
        done_d  = 1'b1;
      end
    end
  end

  always_comb begin
    PRDATA = 32'd0;
    unique case (reg_sel)
      RegCtrl:   PRDATA = {25'd0, last_q, 1'b0, loop_q, 2'b00};
      RegStatus: PRDATA = {25'd0, step_q, 2'b00, done_q, seq_busy};
      RegMask:   PRDATA = mask_q;
      RegIdx:    PRDATA = {29'd0, idx_q};
      RegValue:  PRDATA = value_q[idx_q];
      RegHold:   PRDATA = {16'd0, hold_q[idx_q]};
      default:   PRDATA = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_apb_gpio_seq.sv
// Directed bench for apb_gpio_seq: register access, one-shot, loop, stop/start and reset cases.
module tb_apb_gpio_seq;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic [11:0] PADDR;
  logic [31:0] PWDATA;
  logic        PWRITE;
  logic        PSEL;
  logic        PENABLE;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;
  logic [31:0] seq_out;
  logic [31:0] seq_mask;
  logic        seq_busy;
  logic        irq;

  int n_total = 0;
  int n_bad   = 0;
  logic [31:0] rd;

  localparam logic [11:0] ACtrl   = 12'h000;
  localparam logic [11:0] AStatus = 12'h004;
  localparam logic [11:0] AMask   = 12'h008;
  localparam logic [11:0] AIdx    = 12'h00C;
  localparam logic [11:0] AValue  = 12'h010;
  localparam logic [11:0] AHold   = 12'h014;

  always #5 HCLK = ~HCLK;

  apb_gpio_seq #(.APB_ADDR_WIDTH(12)) dut (
    .HCLK     (HCLK),
    .HRESET   (HRESET),
    .PADDR    (PADDR),
    .PWDATA   (PWDATA),
    .PWRITE   (PWRITE),
    .PSEL     (PSEL),
    .PENABLE  (PENABLE),
    .PRDATA   (PRDATA),
    .PREADY   (PREADY),
    .PSLVERR  (PSLVERR),
    .seq_out  (seq_out),
    .seq_mask (seq_mask),
    .seq_busy (seq_busy),
    .irq      (irq)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called at a negedge; setup edge is the next posedge, access edge the one after.
  // Returns at the negedge just after the access edge.
  task automatic apb_write(input logic [11:0] addr, input logic [31:0] data);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = addr; PWDATA = data;
    @(negedge HCLK);
    PENABLE = 1'b1;
    @(negedge HCLK);
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic apb_read(input logic [11:0] addr, output logic [31:0] data);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = addr;
    @(negedge HCLK);
    PENABLE = 1'b1;
    #1 data = PRDATA;
    @(negedge HCLK);
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic set_step(input logic [2:0] i, input logic [31:0] v, input logic [31:0] h);
    apb_write(AIdx, {29'd0, i});
    apb_write(AValue, v);
    apb_write(AHold, h);
  endtask

  initial begin
    logic [31:0] exp_seq [6];
    exp_seq[0] = 32'hA; exp_seq[1] = 32'hB; exp_seq[2] = 32'hB;
    exp_seq[3] = 32'hB; exp_seq[4] = 32'hC; exp_seq[5] = 32'hC;

    HRESET = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = '0; PWDATA = '0;
    repeat (2) @(posedge HCLK);
    @(negedge HCLK);
    check_eq("rst_out", seq_out, 32'd0);
    check_eq("rst_mask", seq_mask, 32'd0);
    check_eq("rst_busy", {31'd0, seq_busy}, 32'd0);
    check_eq("rst_irq", {31'd0, irq}, 32'd0);
    HRESET = 1'b0;
    apb_read(AStatus, rd); check_eq("rst_status", rd, 32'd0);
    apb_read(ACtrl, rd);   check_eq("rst_ctrl", rd, 32'd0);
    check_eq("pready", {30'd0, PREADY, PSLVERR}, 32'd2);

    // Table programming and readback
    set_step(3'd0, 32'hA, 32'd0);
    set_step(3'd1, 32'hB, 32'hABCD_0002);
    set_step(3'd2, 32'hC, 32'd1);
    apb_read(AIdx, rd); check_eq("idx_rb", rd, 32'd2);
    apb_write(AIdx, 32'd1);
    apb_read(AValue, rd); check_eq("value_rb", rd, 32'hB);
    apb_read(AHold, rd);  check_eq("hold_rb", rd, 32'd2);
    apb_write(AMask, 32'h0000_000F);
    check_eq("mask_out", seq_mask, 32'hF);
    apb_read(AStatus + 12'h040, rd); check_eq("alias_status", rd, 32'd0);
    apb_read(12'h018, rd); check_eq("unmapped", rd, 32'd0);

    // One-shot: A x1, B x3, C x2
    apb_write(ACtrl, 32'h21);
    for (int i = 0; i < 6; i++) begin
      check_eq($sformatf("os_out%0d", i), seq_out, exp_seq[i]);
      check_eq($sformatf("os_bi%0d", i), {30'd0, seq_busy, irq}, 32'd2);
      @(negedge HCLK);
    end
    check_eq("os_done", {30'd0, seq_busy, irq}, 32'd1);
    check_eq("os_hold", seq_out, 32'hC);
    apb_read(ACtrl, rd);   check_eq("os_ctrl", rd, 32'h20);
    apb_read(AStatus, rd); check_eq("os_status", rd, 32'h22);
    check_eq("os_irq_clr", {31'd0, irq}, 32'd0);

    // Single-step sequence (LAST=0, hold 0)
    apb_write(ACtrl, 32'h01);
    check_eq("one_busy", {30'd0, seq_busy, irq}, 32'd2);
    @(negedge HCLK);
    check_eq("one_done", {30'd0, seq_busy, irq}, 32'd1);
    apb_read(AStatus, rd); check_eq("one_status", rd, 32'h02);

    // Loop: hold {1,1}, alternate every 2 cycles
    apb_write(AIdx, 32'd0); apb_write(AHold, 32'd1);
    apb_write(AIdx, 32'd1); apb_write(AHold, 32'd1);
    apb_write(ACtrl, 32'h15);
    for (int i = 0; i < 20; i++) begin
      check_eq($sformatf("lp_out%0d", i), seq_out, ((i / 2) % 2 == 0) ? 32'hA : 32'hB);
      check_eq($sformatf("lp_bi%0d", i), {30'd0, seq_busy, irq}, 32'd2);
      @(negedge HCLK);
    end
    apb_write(ACtrl, 32'h02);
    check_eq("lp_stop", {30'd0, seq_busy, irq}, 32'd0);
    apb_write(AIdx, 32'd0); apb_write(AHold, 32'd0);
    apb_write(AIdx, 32'd1); apb_write(AHold, 32'd2);

    // STOP during step 1
    apb_write(ACtrl, 32'h21);
    apb_write(ACtrl, 32'h02);
    check_eq("stop_busy", {30'd0, seq_busy, irq}, 32'd0);
    check_eq("stop_out", seq_out, 32'hB);
    repeat (3) @(negedge HCLK);
    check_eq("stop_frozen", seq_out, 32'hB);
    apb_read(AStatus, rd); check_eq("stop_status", rd, 32'h10);

    // START and STOP together while running: STOP wins
    apb_write(ACtrl, 32'h21);
    apb_write(ACtrl, 32'h23);
    check_eq("both_busy", {31'd0, seq_busy}, 32'd0);
    check_eq("both_out", seq_out, 32'hB);

    // Restart while at step 2
    apb_write(ACtrl, 32'h21);
    repeat (3) @(negedge HCLK);
    apb_write(ACtrl, 32'h21);
    check_eq("rs_out0", seq_out, 32'hA);
    check_eq("rs_busy", {31'd0, seq_busy}, 32'd1);
    @(negedge HCLK);
    check_eq("rs_out1", seq_out, 32'hB);
    for (int i = 0; i < 20 && seq_busy; i++) @(negedge HCLK);
    check_eq("rs_finish", {30'd0, seq_busy, irq}, 32'd1);
    apb_read(AStatus, rd); check_eq("rs_status", rd, 32'h22);

    // STATUS read on the completion edge: set wins, old value returned
    apb_write(ACtrl, 32'h21);
    repeat (4) @(negedge HCLK);
    apb_read(AStatus, rd); check_eq("col_status", rd, 32'h21);
    check_eq("col_irq", {30'd0, seq_busy, irq}, 32'd1);
    apb_read(AStatus, rd); check_eq("col_status2", rd, 32'h22);
    check_eq("col_irq_clr", {31'd0, irq}, 32'd0);

    // Reset during step 1
    apb_write(ACtrl, 32'h21);
    @(negedge HCLK);
    check_eq("mr_pre", seq_out, 32'hB);
    HRESET = 1'b1;
    @(negedge HCLK);
    check_eq("mr_out", seq_out, 32'd0);
    check_eq("mr_mask", seq_mask, 32'd0);
    check_eq("mr_bi", {30'd0, seq_busy, irq}, 32'd0);
    HRESET = 1'b0;
    apb_read(ACtrl, rd); check_eq("mr_ctrl", rd, 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/apb_gpio_seq.md
# apb_gpio_seq

APB-programmable pattern sequencer that drives timed output waveforms onto GPIO pins without core involvement. Plays an 8-entry table of (value, hold) steps, once or looped, and raises an interrupt on completion. Sits beside `apb_gpio` in the peripheral subsystem. Integration muxes each pin per bit: `seq_mask[i] ? seq_out[i] : gpio_out[i]`.

## Interface
- `APB_ADDR_WIDTH`, 12, APB address width (4KB slave window)
- `HCLK` in 1 — sole clock, all logic on rising edge
- `HRESET` in 1 — synchronous, active-high reset
- `PADDR` in APB_ADDR_WIDTH — register select is `PADDR[5:2]`
- `PWDATA` in 32 — write data
- `PWRITE` in 1 — 1 = write
- `PSEL` in 1 — slave select
- `PENABLE` in 1 — access phase
- `PRDATA` out 32 — read data, combinational from `PADDR[5:2]`
- `PREADY` out 1 — tied 1 (zero wait states)
- `PSLVERR` out 1 — tied 0
- `seq_out` out 32 — current step value
- `seq_mask` out 32 — pins owned by the sequencer
- `seq_busy` out 1 — sequence running
- `irq` out 1 — completion interrupt (level)

## Operation
- Access: a transfer takes effect on the edge where `PSEL & PENABLE`.
- Register map (word offsets; unmapped addresses read 0, writes ignored):
  - 0x00 CTRL: bit0 START (W1, reads 0); bit1 STOP (W1, reads 0); bit2 LOOP (RW); bits[6:4] LAST, index of the final step (RW).
  - 0x04 STATUS (RO): bit0 busy; bit1 done; bits[6:4] current step. A read clears done.
  - 0x08 MASK (RW): drives `seq_mask`.
  - 0x0C IDX (RW): bits[2:0], table pointer.
  - 0x10 VALUE (RW): table value[IDX], 32 bits.
  - 0x14 HOLD (RW): bits[15:0], table hold[IDX]. Upper bits read 0.
- Table, MASK and IDX are writable at any time. A table edit affects a step only when that step is next loaded.
- FSM states IDLE and RUN. Registers: step (3b), cnt (16b).
  - IDLE + START: RUN, step←0, `seq_out`←value[0], cnt←hold[0], done←0.
  - RUN with cnt≠0: cnt←cnt−1.
  - RUN with cnt=0 and step≠LAST: step←step+1, load value and hold of the new step.
  - RUN with cnt=0, step=LAST, LOOP=1: reload step 0.
  - RUN with cnt=0, step=LAST, LOOP=0: IDLE, done←1.
  - RUN + START: restart at step 0, exactly as from IDLE.
  - Any state + STOP: IDLE, done unchanged, `seq_out` holds its value.
  - STOP and START written together: STOP wins.
- `seq_out` holds the last value driven whenever the FSM is IDLE.
- `seq_busy` = (state==RUN). `irq` = done.
- done set and STATUS read on the same edge: set wins. The read returns the old value.

## Timing
- Reset values: `seq_out`=0, `seq_mask`=0, `seq_busy`=0, `irq`=0; state IDLE; step=0; cnt=0; LOOP=0; LAST=0; IDX=0.
- Table contents are not reset. Reads before writes return X.
- START written on edge T:
  - `seq_out`=value[0] and `seq_busy`=1 from T+1.
  - Step k is visible for exactly hold[k]+1 cycles.
- One-shot total RUN time = Σ_{k=0..LAST}(hold[k]+1) cycles. `irq` rises on the edge that leaves RUN; `seq_busy` falls on the same edge.
- Looping wraps LAST→0 with no gap cycle.
- hold=0 gives a 1-cycle step.
- LAST=0 gives a single-step sequence.
- Register writes are visible in `PRDATA` and `seq_mask` one cycle after the access edge.
- `HRESET` mid-sequence forces all reset values on the next edge.

## Test plan
- Reset: assert `HRESET` 2 cycles → all outputs 0, `PRDATA` for STATUS = 0.
- One-shot: value={0xA,0xB,0xC}, hold={0,2,1}, LAST=2, LOOP=0, START at T:
  - `seq_out` = 0xA for 1 cycle, 0xB for 3 cycles, 0xC for 2 cycles.
  - `irq`=1 at T+6; `seq_out` stays 0xC.
  - STATUS read → 0x22, then `irq`=0.
- Loop: LAST=1, hold={1,1}, LOOP=1 → `seq_out` alternates value0/value1 every 2 cycles for 20 cycles. `irq` never asserts.
- STOP/START: STOP mid-step 1 → `seq_busy`=0 next cycle, `seq_out` frozen, done=0. CTRL=0x3 while running → STOP wins.
- Restart and collision:
  - START while running at step 2 → step 0 loaded on the next edge.
  - STATUS read on the completion edge → read returns done=0 and `irq` stays 1.
- Reset mid-run: `HRESET` during step 1 → `seq_out`=0, `seq_mask`=0, `seq_busy`=0 next cycle.
